fetch_decode_fsm: RTL
=====================

# fetch_decode_fsm

Instruction fetch/decode sequencer for the microcontroller datapath, directly upstream of the execution FSMs (load, store, add, sub). It drives the bus control strobes that move PC→MAR, memory→MDR→IR and increment PC. It then decodes IR into an opcode and two 6-bit register-select parameters. Finally it launches the matching execution FSM with `donefetch`/`start`, holding `parameter1`/`parameter2` stable until that FSM reports `done`.

## Interface
Parameters:
- `MEM_WAIT`, 2: cycles `EN` is held in the memory-read state (legal range 1–15).
- `TIMEOUT`, 64: maximum EXEC cycles before the watchdog halts (legal range 2–255).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  1 = fetch continuously; 0 = stop at the next instruction boundary.
- `ir_in`  in  16  IR contents: [15:12] opcode, [11:6] parameter1, [5:0] parameter2.
- `done_in`  in  4  done from execution units: [0] load, [1] store, [2] add, [3] sub.
- `PCout`  out  1  PC drives bus.
- `MARin`  out  1  MAR loads from bus.
- `EN`  out  1  memory enable.
- `RW`  out  1  memory direction; always 0 (read) from this block.
- `MDRout`  out  1  MDR drives bus.
- `IRin`  out  1  IR loads from bus.
- `PCinc`  out  1  PC increments by 1.
- `donefetch`  out  1  one-cycle pulse: fetch complete, parameters valid.
- `start`  out  4  one-hot start to execution units, same bit order as `done_in`.
- `parameter1`  out  6  decoded register select 1 (registered).
- `parameter2`  out  6  decoded register select 2 (registered).
- `halted`  out  1  sticky; block stopped by HALT, illegal opcode or timeout.
- `fault`  out  2  sticky cause: 00 none/HALT, 01 illegal opcode, 10 timeout.

## Operation
- Moore FSM. Strobes are decoded from the state only. `parameter1`, `parameter2`, `fault` and the counters are registers.
- States and outputs:
  - IDLE: all strobes 0. Go to F_ADDR when `run`=1.
  - F_ADDR: `PCout`=`MARin`=1. Go to F_MEM.
  - F_MEM: `EN`=1, `RW`=0, held `MEM_WAIT` cycles via a wait counter. Go to F_IR.
  - F_IR: `MDRout`=`IRin`=`PCinc`=1. Go to DECODE.
  - DECODE: `donefetch`=1. Latch `ir_in[11:6]`→`parameter1` and `ir_in[5:0]`→`parameter2`. Transition by opcode:
    - 0000 NOP → NEXT.
    - 0001/0010/0011/0100 (load/store/add/sub) → EXEC, selecting unit 0/1/2/3.
    - 1111 HALT → HALTED, `fault`=00.
    - any other opcode → HALTED, `fault`=01.
  - EXEC: `start[k]`=1, held as a level for the selected unit k. Leave when `done_in[k]`=1 → NEXT. If `TIMEOUT` cycles elapse in EXEC without it → HALTED, `fault`=10.
  - NEXT: resolves the boundary in 0 extra cycles. It is a combinational decision, not a state: `run`=1 → F_ADDR, else → IDLE.
  - HALTED: `halted`=1, all strobes 0. Only `rst` exits.
- `done_in` bits other than k are ignored in EXEC. All of `done_in` is ignored outside EXEC.
- `parameter1`/`parameter2` change only in DECODE and hold through EXEC.
- `run` falling mid-instruction has no effect until the boundary; the current instruction completes.

## Timing
- Reset, taking effect at the next edge with `rst`=1, even mid-EXEC or in HALTED:
  - state IDLE;
  - every output 0, including `parameter1`, `parameter2`, `halted`, `fault`, `start`;
  - wait and timeout counters cleared.
- Fetch latency: entering F_ADDR at cycle 0 gives DECODE at cycle 2+`MEM_WAIT`. The first `start` cycle is 3+`MEM_WAIT`; with defaults, F_ADDR c0, F_MEM c1–c2, F_IR c3, DECODE c4, EXEC c5.
- `ir_in` is sampled in DECODE, one cycle after `IRin`.
- `done_in[k]` high in the first EXEC cycle is accepted. `start` is then high for exactly 1 cycle, and the next cycle is F_ADDR (`run`=1) or IDLE.
- Back-to-back instructions: the last EXEC cycle is followed immediately by F_ADDR, with no idle bubble.
- Timeout counter: cleared on entering EXEC, incremented each EXEC cycle without a matching done. When it reaches `TIMEOUT`-1 without done, the next state is HALTED. A done in that same cycle takes priority.

## Test plan
- Reset then `run`=1, `ir_in`=16'h2102 (store, p1=000100, p2=000010), `done_in[1]` asserted 3 cycles after `start[1]` → strobe sequence F_ADDR c0, F_MEM c1–2, F_IR c3, `donefetch` c4, `start`=0010 c5–c8, then F_ADDR c9.
- NOP (16'h0000) followed by add (16'h3041) → no `start` for the NOP; second `PCout` 5 cycles after the first; add's `start`=0100 with `parameter1`=000001, `parameter2`=000001.
- Opcode 16'hF000 → `halted`=1, `fault`=00, no further strobes over 20 cycles while `run`=1; `rst` → all outputs 0, IDLE.
- Opcode 16'h7000 → `halted`=1, `fault`=01. Separately, load with `done_in` held 0 → HALTED, `fault`=10, exactly `TIMEOUT` cycles after `start[0]` rose.
- `run` dropped during F_MEM of a sub with `done_in[2]` (wrong unit) pulsed, then `done_in[3]` → wrong done ignored, sub completes, block enters IDLE.
- `rst` asserted during EXEC with `start[1]`=1 → next cycle every output 0, state IDLE; refetch begins when `rst` drops and `run`=1.

Source files
------------

// File: rtl/fetch_decode_fsm.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_fsm
// Purpose  : Instruction fetch/decode sequencer. Drives the bus strobes that
//            move PC->MAR, memory->MDR->IR and increment PC. It then decodes
//            IR into an opcode plus two 6-bit register selects, and launches
//            the matching execution unit (load/store/add/sub). The selects
//            are held stable until that unit reports done.
// Ports    : clk, rst (sync, active-high), run (fetch enable),
//            ir_in[15:0] (IR contents), done_in[3:0] (unit done flags),
//            PCout/MARin/EN/RW/MDRout/IRin/PCinc (bus strobes),
//            donefetch (decode pulse), start[3:0] (one-hot unit start),
//            parameter1/parameter2 (decoded selects), halted, fault[1:0].
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode_fsm #(
  parameter int MEM_WAIT = 2,   // cycles EN is held (1..15)
  parameter int TIMEOUT  = 64   // max EXEC cycles before watchdog halt (2..255)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] ir_in,
  input  logic [3:0]  done_in,
  output logic        PCout,
  output logic        MARin,
  output logic        EN,
  output logic        RW,
  output logic        MDRout,
  output logic        IRin,
  output logic        PCinc,
  output logic        donefetch,
  output logic [3:0]  start,
  output logic [5:0]  parameter1,
  output logic [5:0]  parameter2,
  output logic        halted,
  output logic [1:0]  fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FADDR  = 3'd1,
    S_FMEM   = 3'd2,
    S_FIR    = 3'd3,
    S_DECODE = 3'd4,
    S_EXEC   = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  localparam logic [3:0] c_WAIT_LAST = 4'(MEM_WAIT - 1);
  localparam logic [7:0] c_TO_LAST   = 8'(TIMEOUT - 1);

  localparam logic [3:0] c_OP_NOP   = 4'h0;
  localparam logic [3:0] c_OP_LOAD  = 4'h1;
  localparam logic [3:0] c_OP_STORE = 4'h2;
  localparam logic [3:0] c_OP_ADD   = 4'h3;
  localparam logic [3:0] c_OP_SUB   = 4'h4;
  localparam logic [3:0] c_OP_HALT  = 4'hF;

  localparam logic [1:0] c_FAULT_NONE    = 2'b00;
  localparam logic [1:0] c_FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] c_FAULT_TIMEOUT = 2'b10;

  state_t      state_q, state_d;
  logic [3:0]  wait_q;
  logic [7:0]  to_q;
  logic [1:0]  unit_q, unit_d;
  logic [1:0]  fault_q, fault_d;
  logic [3:0]  opcode;

  logic        pcout_q, marin_q, en_q, mdrout_q, irin_q, pcinc_q;
  logic        donefetch_q, halted_q;
  logic [3:0]  start_q;
  logic [5:0]  p1_q, p2_q;

  assign opcode = ir_in[15:12];

  // --------------------------------------------------------------------------
  // Next-state decision. The instruction boundary is not a state of its own:
  // the last cycle of an instruction jumps straight to F_ADDR or IDLE, so
  // back-to-back instructions run with no bubble.
  // --------------------------------------------------------------------------
  always_comb begin
    state_t boundary;
    boundary = run ? S_FADDR : S_IDLE;
    state_d  = state_q;
    unit_d   = unit_q;
    fault_d  = fault_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FADDR;
      S_FADDR:  state_d = S_FMEM;
      S_FMEM:   if (wait_q == c_WAIT_LAST) state_d = S_FIR;
      S_FIR:    state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          c_OP_NOP: state_d = boundary;
          c_OP_LOAD, c_OP_STORE, c_OP_ADD, c_OP_SUB: begin
            state_d = S_EXEC;
            unit_d  = 2'(opcode - 4'd1);
          end
          c_OP_HALT: begin
            state_d = S_HALTED;
            fault_d = c_FAULT_NONE;
          end
          default: begin
            state_d = S_HALTED;
            fault_d = c_FAULT_ILLEGAL;
          end
        endcase
      end
      S_EXEC: begin
        // A done in the final watchdog cycle still wins over the timeout.
        if (done_in[unit_q]) begin
          state_d = boundary;
        end else if (to_q == c_TO_LAST) begin
          state_d = S_HALTED;
          fault_d = c_FAULT_TIMEOUT;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counters and outputs. Outputs are registered from the next state,
  // so each strobe is high exactly while the FSM sits in its state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_q      <= 4'd0;
      to_q        <= 8'd0;
      unit_q      <= 2'd0;
      fault_q     <= c_FAULT_NONE;
      pcout_q     <= 1'b0;
      marin_q     <= 1'b0;
      en_q        <= 1'b0;
      mdrout_q    <= 1'b0;
      irin_q      <= 1'b0;
      pcinc_q     <= 1'b0;
      donefetch_q <= 1'b0;
      start_q     <= 4'd0;
      halted_q    <= 1'b0;
      p1_q        <= 6'd0;
      p2_q        <= 6'd0;
    end else begin
      state_q  <= state_d;
      unit_q   <= unit_d;
      fault_q  <= fault_d;
      // Both counters restart from zero every time their state is entered.
      wait_q   <= (state_q == S_FMEM) ? wait_q + 4'd1 : 4'd0;
      to_q     <= (state_q == S_EXEC) ? to_q + 8'd1 : 8'd0;
      // IR is valid in DECODE, one cycle after IRin loaded it.
      if (state_q == S_DECODE) begin
        p1_q <= ir_in[11:6];
        p2_q <= ir_in[5:0];
      end
      pcout_q     <= (state_d == S_FADDR);
      marin_q     <= (state_d == S_FADDR);
      en_q        <= (state_d == S_FMEM);
      mdrout_q    <= (state_d == S_FIR);
      irin_q      <= (state_d == S_FIR);
      pcinc_q     <= (state_d == S_FIR);
      donefetch_q <= (state_d == S_DECODE);
      start_q     <= (state_d == S_EXEC) ? (4'b0001 << unit_d) : 4'd0;
      halted_q    <= (state_d == S_HALTED);
    end
  end

  assign PCout      = pcout_q;
  assign MARin      = marin_q;
  assign EN         = en_q;
  assign RW         = 1'b0;   // this block only ever reads memory
  assign MDRout     = mdrout_q;
  assign IRin       = irin_q;
  assign PCinc      = pcinc_q;
  assign donefetch  = donefetch_q;
  assign start      = start_q;
  assign parameter1 = p1_q;
  assign parameter2 = p2_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule
`default_nettype wire
